// File: rtl/vr16_pkg.sv
// VR16 shared definitions: datapath width,
// register indices and reset value.
package vr16_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_REGS   = 4;
  localparam int SEL_WIDTH  = 2;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [SEL_WIDTH-1:0]  reg_sel_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  localparam reg_sel_t REG_A = 2'b00;
  localparam reg_sel_t REG_B = 2'b01;
  localparam reg_sel_t REG_C = 2'b10;
  localparam reg_sel_t REG_D = 2'b11;

  localparam word_t GPR_RESET_VALUE = 16'h0000;

  // One-hot load mask for a write; all-zero when the
  // write is disabled so a stray select cannot matter.
  function automatic reg_mask_t write_mask(
    input logic     en,
    input reg_sel_t sel
  );
    reg_mask_t m;
    m = '0;
    if (en) begin
      case (sel)
        REG_A:   m = 4'b0001;
        REG_B:   m = 4'b0010;
        REG_C:   m = 4'b0100;
        REG_D:   m = 4'b1000;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/gpr_cell.sv
// Single general-purpose register cell with
// async active-low clear and load enable.
module gpr_cell
  import vr16_pkg::*;
#(
  parameter int                    WIDTH   = DATA_WIDTH,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load; otherwise load or hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/gp_registers.sv
// VR16 A/B/C/D register file: one write port,
// all four registers visible on dedicated outputs.
module gp_registers
  import vr16_pkg::*;
#(
  parameter int                    DATA_WIDTH  = vr16_pkg::DATA_WIDTH,
  parameter int                    NUM_REGS    = vr16_pkg::NUM_REGS,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = GPR_RESET_VALUE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [1:0]            select_reg,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] reg_a_out,
  output logic [DATA_WIDTH-1:0] reg_b_out,
  output logic [DATA_WIDTH-1:0] reg_c_out,
  output logic [DATA_WIDTH-1:0] reg_d_out
);

  logic [3:0] load;

  // Decode the select into a one-hot load, gated by write_enable.
  always_comb begin
    load = write_mask(write_enable, select_reg);
  end

  gpr_cell #(
    .WIDTH   (DATA_WIDTH),
    .RST_VAL (RESET_VALUE)
  ) u_reg_a (
    .clk   (clk),
    .reset (reset),
    .load  (load[REG_A]),
    .d     (alu_result),
    .q     (reg_a_out)
  );

  gpr_cell #(
    .WIDTH   (DATA_WIDTH),
    .RST_VAL (RESET_VALUE)
  ) u_reg_b (
    .clk   (clk),
    .reset (reset),
    .load  (load[REG_B]),
    .d     (alu_result),
    .q     (reg_b_out)
  );

  gpr_cell #(
    .WIDTH   (DATA_WIDTH),
    .RST_VAL (RESET_VALUE)
  ) u_reg_c (
    .clk   (clk),
    .reset (reset),
    .load  (load[REG_C]),
    .d     (alu_result),
    .q     (reg_c_out)
  );

  gpr_cell #(
    .WIDTH   (DATA_WIDTH),
    .RST_VAL (RESET_VALUE)
  ) u_reg_d (
    .clk   (clk),
    .reset (reset),
    .load  (load[REG_D]),
    .d     (alu_result),
    .q     (reg_d_out)
  );

endmodule

// File: tb/tb_gp_registers.sv
// Self-checking bench for gp_registers using an
// expected-snapshot scoreboard queue.
module tb_gp_registers;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic [1:0]  select_reg;
  logic [15:0] alu_result;
  logic [15:0] reg_a_out;
  logic [15:0] reg_b_out;
  logic [15:0] reg_c_out;
  logic [15:0] reg_d_out;

  int tests;
  int fails;

  logic [15:0] model [4];
  logic [63:0] sb [$];
  logic [63:0] got;
  logic [63:0] exp_v;

  gp_registers dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .select_reg   (select_reg),
    .alu_result   (alu_result),
    .reg_a_out    (reg_a_out),
    .reg_b_out    (reg_b_out),
    .reg_c_out    (reg_c_out),
    .reg_d_out    (reg_d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] snap_model();
    return {model[0], model[1], model[2], model[3]};
  endfunction

  // Drive one cycle of stimulus, update the model and
  // push the expected post-edge snapshot.
  task automatic drive(input logic we_i,
                       input logic [1:0] sel_i,
                       input logic [15:0] d_i);
    @(negedge clk);
    write_enable = we_i;
    select_reg   = sel_i;
    alu_result   = d_i;
    if (we_i === 1'b1 && reset === 1'b1)
      model[sel_i] = d_i;
    sb.push_back(snap_model());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 16'h0000;
    drive(1'b1, 2'b00, 16'hFFFF);
    drive(1'b1, 2'b11, 16'hBEEF);
    for (int i = 0; i < 2; i++) begin
      got   = {reg_a_out, reg_b_out, reg_c_out, reg_d_out};
      exp_v = sb.pop_front();
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL reset_state got=%h exp=%h", got, exp_v);
      end
    end
    @(negedge clk);
    reset        = 1'b1;
    write_enable = 1'b0;
  endtask

  task automatic test_single_write();
    drive(1'b1, 2'b00, 16'h1111);
    got   = {reg_a_out, reg_b_out, reg_c_out, reg_d_out};
    exp_v = sb.pop_front();
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL single_write got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_select_hold();
    drive(1'b1, 2'b11, 16'h1111);
    drive(1'b0, 2'b01, 16'hFFFF);
    drive(1'b0, 2'b01, 16'hFFFF);
    drive(1'b0, 2'b10, 16'h0F0F);
    drive(1'b0, 2'bxx, 16'hxxxx);
    while (sb.size() > 0) begin
      got   = {reg_a_out, reg_b_out, reg_c_out, reg_d_out};
      exp_v = sb.pop_front();
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL select_hold got=%h exp=%h", got, exp_v);
      end
      if (sb.size() > 0) begin
        sb.push_front(sb.pop_front());
      end
    end
  endtask

  task automatic test_walk();
    logic [15:0] vals [4];
    vals[0] = 16'hA5A5;
    vals[1] = 16'h5A5A;
    vals[2] = 16'h8001;
    vals[3] = 16'h7FFE;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), vals[i]);
      got   = {reg_a_out, reg_b_out, reg_c_out, reg_d_out};
      exp_v = sb.pop_front();
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL walk_%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [2];
    vals[0] = 16'h0001;
    vals[1] = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b10, vals[i]);
      got   = {reg_a_out, reg_b_out, reg_c_out, reg_d_out};
      exp_v = sb.pop_front();
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL b2b_%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'b01, 16'h3C3C);
    got   = {reg_a_out, reg_b_out, reg_c_out, reg_d_out};
    exp_v = sb.pop_front();
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL preload got=%h exp=%h", got, exp_v);
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 16'h0000;
    sb.push_back(snap_model());
    #1;
    got   = {reg_a_out, reg_b_out, reg_c_out, reg_d_out};
    exp_v = sb.pop_front();
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL async_clear got=%h exp=%h", got, exp_v);
    end
    drive(1'b1, 2'b00, 16'hDEAD);
    drive(1'b1, 2'b10, 16'hCAFE);
    for (int i = 0; i < 2; i++) begin
      got   = {reg_a_out, reg_b_out, reg_c_out, reg_d_out};
      exp_v = sb.pop_front();
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL reset_hold got=%h exp=%h", got, exp_v);
      end
    end
    @(negedge clk);
    reset        = 1'b1;
    write_enable = 1'b0;
  endtask

  task automatic test_reset_collision();
    drive(1'b1, 2'b10, 16'h5555);
    got   = {reg_a_out, reg_b_out, reg_c_out, reg_d_out};
    exp_v = sb.pop_front();
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL coll_pre got=%h exp=%h", got, exp_v);
    end
    @(negedge clk);
    write_enable = 1'b1;
    select_reg   = 2'b10;
    alu_result   = 16'h1234;
    for (int i = 0; i < 4; i++) model[i] = 16'h0000;
    sb.push_back(snap_model());
    @(posedge clk);
    reset = 1'b0;
    #1;
    got   = {reg_a_out, reg_b_out, reg_c_out, reg_d_out};
    exp_v = sb.pop_front();
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL collision got=%h exp=%h", got, exp_v);
    end
    #1;
    write_enable = 1'b0;
    reset        = 1'b1;
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    reset        = 1'b0;
    write_enable = 1'b0;
    select_reg   = 2'b00;
    alu_result   = 16'h0000;
    test_reset();
    test_single_write();
    test_select_hold();
    test_walk();
    test_back_to_back();
    test_async_reset();
    test_reset_collision();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
